fifo_word_packer: RTL and testbench

Downstream drain stage for `syn_fifo`. Pops words from the FIFO read port and packs `PACK` consecutive words into one wide output word, lane 0 first. Presents each packed word on a valid/ready stream to the next consumer (bus master or wide memory writer). Assumes the FIFO's registered read: `data_out` is valid the cycle after `read_en` is sampled with `empty` = 0.

---
 rtl/fifo_word_packer.sv | 113 +++++++++++
 tb/tb_fifo_word_packer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Drains a registered-read FIFO and packs PACK words (lane 0 first) into one valid/ready output word.
// Optional partial-word flush (flush / m_lanes ports) is built when PACKER_FLUSH_EN is defined.
module fifo_word_packer #(
   parameter int IN_WIDTH = 16,
   parameter int PACK     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [IN_WIDTH-1:0]          fifo_data_out,
   input  logic                         fifo_empty,
   output logic                         fifo_read_en,
   output logic [PACK*IN_WIDTH-1:0]     m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         idle
`ifdef PACKER_FLUSH_EN
   ,
   input  logic                         flush,
   output logic [$clog2(PACK+1)-1:0]    m_lanes
`endif
);

   localparam int CNT_W = $clog2(PACK + 1);
   localparam int OUT_W = PACK * IN_WIDTH;
   localparam logic [CNT_W-1:0] PACK_C = CNT_W'(PACK);

   logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
   logic             rd_pending_q;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic [CNT_W-1:0] cnt_after;
   logic [CNT_W:0]   in_use;
   logic             out_free;
   logic             flush_act;
   logic             flush_load;
   logic             load;

   // Lanes at or above n are forced to zero so stale accumulator data never leaks out.
   function automatic logic [OUT_W-1:0] lane_mask(input logic [CNT_W-1:0] n);
      logic [OUT_W-1:0] m;
      m = '0;
      for (int k = 0; k < PACK; k++) begin
         if (k < int'(n)) m[k*IN_WIDTH +: IN_WIDTH] = '1;
      end
      return m;
   endfunction

`ifdef PACKER_FLUSH_EN
   logic [CNT_W-1:0] m_lanes_q, m_lanes_d;
   assign flush_act = flush;
   assign m_lanes   = m_lanes_q;
`else
   assign flush_act = 1'b0;
`endif

   // Lanes already held plus the read in flight bound how many more reads may issue.
   assign in_use       = {1'b0, lane_cnt_q} + {{CNT_W{1'b0}}, rd_pending_q};
   assign fifo_read_en = !rst && !fifo_empty && !flush_act && (in_use < (CNT_W+1)'(PACK));

   always_comb begin
      acc_d     = acc_q;
      cnt_after = lane_cnt_q + CNT_W'(rd_pending_q);
      if (rd_pending_q) begin
         for (int k = 0; k < PACK; k++) begin
            if (lane_cnt_q == CNT_W'(k)) acc_d[k*IN_WIDTH +: IN_WIDTH] = fifo_data_out;
         end
      end
   end

   assign out_free   = !m_valid_q || m_ready;
   assign flush_load = flush_act && !rd_pending_q && (lane_cnt_q != '0);
   assign load       = out_free && ((cnt_after == PACK_C) || flush_load);

   always_comb begin
      lane_cnt_d = load ? '0 : cnt_after;
      m_data_d   = load ? (acc_d & lane_mask(cnt_after)) : m_data_q;
      m_valid_d  = load || (m_valid_q && !m_ready);
`ifdef PACKER_FLUSH_EN
      m_lanes_d  = load ? cnt_after : m_lanes_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_cnt_q   <= '0;
         rd_pending_q <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
`ifdef PACKER_FLUSH_EN
         m_lanes_q    <= '0;
`endif
      end else begin
         lane_cnt_q   <= lane_cnt_d;
         rd_pending_q <= fifo_read_en;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
`ifdef PACKER_FLUSH_EN
         m_lanes_q    <= m_lanes_d;
`endif
      end
   end

   // Accumulator is pure data; reset-time contents are hidden by lane_mask on every load.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign idle    = (lane_cnt_q == '0) && !rd_pending_q && !m_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (PACK=2) with a registered-read FIFO model.
// With PACKER_FLUSH_EN defined, a second PACK=4 instance exercises the partial-word flush.
module tb_fifo_word_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_rst;
   logic [15:0] fifo_data_out;
   logic        fifo_empty;
   logic        fifo_read_en;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        idle;
`ifdef PACKER_FLUSH_EN
   logic        flush0 = 1'b0;
   logic [1:0]  m_lanes0;
`endif

   int n_tot  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fifo_word_packer #(.IN_WIDTH(16), .PACK(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_data_out(fifo_data_out),
      .fifo_empty   (fifo_empty),
      .fifo_read_en (fifo_read_en),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .idle         (idle)
`ifdef PACKER_FLUSH_EN
      ,
      .flush        (flush0),
      .m_lanes      (m_lanes0)
`endif
   );

   // FIFO model: registered read, popped when read_en is sampled while non-empty.
   logic [15:0] mem [0:63];
   int wr_n = 0;
   int rd_p = 0;
   assign fifo_empty = (wr_n == rd_p);

   always @(posedge clk) begin
      if (fifo_rst) rd_p <= wr_n;
      else if (fifo_read_en && !fifo_empty) begin
         fifo_data_out <= mem[rd_p];
         rd_p          <= rd_p + 1;
      end
   end

   task automatic push(input logic [15:0] v);
      mem[wr_n] = v;
      wr_n++;
   endtask

   // Output / read monitor.
   logic [31:0] out_data [0:63];
   int out_cyc [0:63];
   int out_n  = 0;
   int rd_n   = 0;
   int bad_rd = 0;
   int cyc    = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_valid && m_ready) begin
         out_data[out_n] <= m_data;
         out_cyc[out_n]  <= cyc;
         out_n           <= out_n + 1;
      end
      if (fifo_read_en) begin
         rd_n <= rd_n + 1;
         if (fifo_empty) bad_rd <= bad_rd + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_outs(input int n, input int budget);
      int c = 0;
      while (out_n < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("wait_outs", 64'(out_n >= n), 64'd1);
   endtask

`ifdef PACKER_FLUSH_EN
   logic [15:0] f_data;
   logic        f_empty, f_rd, f_valid, f_idle;
   logic        f_ready = 1'b1;
   logic        f_flush = 1'b0;
   logic [63:0] f_mdata;
   logic [2:0]  f_lanes;
   logic [15:0] f_mem [0:7];
   int f_wr = 0;
   int f_rp = 0;
   assign f_empty = (f_wr == f_rp);

   always @(posedge clk) begin
      if (f_rd && !f_empty) begin
         f_data <= f_mem[f_rp];
         f_rp   <= f_rp + 1;
      end
   end

   fifo_word_packer #(.IN_WIDTH(16), .PACK(4)) u_f (
      .clk          (clk),
      .rst          (rst),
      .fifo_data_out(f_data),
      .fifo_empty   (f_empty),
      .fifo_read_en (f_rd),
      .m_data       (f_mdata),
      .m_valid      (f_valid),
      .m_ready      (f_ready),
      .idle         (f_idle),
      .flush        (f_flush),
      .m_lanes      (f_lanes)
   );
`endif

   initial begin
      int base_o;
      int base_r;
      rst      = 1'b1;
      fifo_rst = 1'b0;
      m_ready  = 1'b1;

      // Reset with a non-empty FIFO: no reads, nothing valid.
      push(16'h0011);
      push(16'h0022);
      repeat (3) begin
         @(negedge clk);
         chk("rst_rd_en", 64'(fifo_read_en), 64'd0);
         chk("rst_valid", 64'(m_valid), 64'd0);
         chk("rst_idle",  64'(idle), 64'd1);
      end
      chk("rst_data", 64'(m_data), 64'd0);

      // Basic pack.
      rst = 1'b0;
      #1 chk("basic_rd0", 64'(fifo_read_en), 64'd1);
      @(negedge clk);
      chk("basic_rd1", 64'(fifo_read_en), 64'd1);
      chk("basic_valid_early", 64'(m_valid), 64'd0);
      @(negedge clk);
      chk("basic_rd2", 64'(fifo_read_en), 64'd0);
      chk("basic_valid_early2", 64'(m_valid), 64'd0);
      @(negedge clk);
      chk("basic_valid", 64'(m_valid), 64'd1);
      chk("basic_data", 64'(m_data), 64'h0000_0000_0022_0011);
      @(negedge clk);
      chk("basic_valid_drop", 64'(m_valid), 64'd0);
      chk("basic_idle", 64'(idle), 64'd1);

      // Streaming 16 words.
      base_o = out_n;
      base_r = rd_n;
      for (int v = 1; v <= 16; v++) push(16'(v));
      wait_outs(base_o + 8, 80);
      for (int k = 0; k < 8; k++) begin
         chk("stream_data", 64'(out_data[base_o+k]), 64'({16'(2*k+2), 16'(2*k+1)}));
         if (k > 0) chk("stream_gap", 64'(out_cyc[base_o+k] - out_cyc[base_o+k-1]), 64'd3);
      end
      repeat (4) @(negedge clk);
      chk("stream_reads", 64'(rd_n - base_r), 64'd16);
      chk("no_read_when_empty", 64'(bad_rd), 64'd0);

      // Backpressure.
      m_ready = 1'b0;
      base_o  = out_n;
      base_r  = rd_n;
      for (int v = 1; v <= 6; v++) push(16'(v));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 3) begin
            chk("bp_valid", 64'(m_valid), 64'd1);
            chk("bp_hold",  64'(m_data), 64'h0000_0000_0002_0001);
         end
      end
      chk("bp_reads_stop", 64'(rd_n - base_r), 64'd4);
      chk("bp_not_idle", 64'(idle), 64'd0);
      m_ready = 1'b1;
      wait_outs(base_o + 3, 40);
      chk("bp_out0", 64'(out_data[base_o]),   64'h0000_0000_0002_0001);
      chk("bp_out1", 64'(out_data[base_o+1]), 64'h0000_0000_0004_0003);
      chk("bp_out2", 64'(out_data[base_o+2]), 64'h0000_0000_0006_0005);
      chk("bp_reads_total", 64'(rd_n - base_r), 64'd6);

      // Reset mid-word.
      repeat (4) @(negedge clk);
      base_o = out_n;
      push(16'h0055);
      push(16'h0066);
      #1 chk("mid_rd0", 64'(fifo_read_en), 64'd1);
      @(negedge clk);
      rst      = 1'b1;
      fifo_rst = 1'b1;
      #1 chk("mid_rd_in_rst", 64'(fifo_read_en), 64'd0);
      @(negedge clk);
      chk("mid_valid", 64'(m_valid), 64'd0);
      chk("mid_idle",  64'(idle), 64'd1);
      rst      = 1'b0;
      fifo_rst = 1'b0;
      push(16'hAAAA);
      push(16'hBBBB);
      wait_outs(base_o + 1, 20);
      chk("mid_after_data", 64'(out_data[base_o]), 64'h0000_0000_BBBB_AAAA);
      repeat (4) @(negedge clk);
      chk("mid_out_count", 64'(out_n - base_o), 64'd1);

`ifdef PACKER_FLUSH_EN
      // Partial-word flush on the PACK=4 instance.
      f_mem[0] = 16'h0005;
      f_mem[1] = 16'h0006;
      f_mem[2] = 16'h0007;
      f_wr     = 3;
      repeat (8) @(negedge clk);
      chk("fl_no_partial", 64'(f_valid), 64'd0);
      chk("fl_not_idle",   64'(f_idle), 64'd0);
      chk("fl_main_lanes", 64'(m_lanes0), 64'd2);
      f_flush = 1'b1;
      begin
         int c = 0;
         while (!f_valid && c < 10) begin
            @(negedge clk);
            c++;
         end
      end
      chk("fl_valid", 64'(f_valid), 64'd1);
      chk("fl_data",  f_mdata, 64'h0000_0007_0006_0005);
      chk("fl_lanes", 64'(f_lanes), 64'd3);
      @(negedge clk);
      chk("fl_idle", 64'(f_idle), 64'd1);
      f_flush = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
      $finish;
   end

endmodule
